// File: rtl/spi_reg_slave_pkg.sv
// Shared definitions for the SPI register responder: default geometry,
// frame field positions and the FSM state encoding.
package spi_reg_slave_pkg;

    localparam int          ADDR_W_DEF      = 3;
    localparam int          DATA_W_DEF      = 8;
    localparam logic [7:0]  ID_VAL_DEF      = 8'hA5;
    localparam int          SYNC_STAGES_DEF = 2;

    // Field positions of the default 12-bit command {rw, addr[2:0], wdata[7:0]}
    localparam int FL_DEF   = 1 + ADDR_W_DEF + DATA_W_DEF;
    localparam int RW_BIT   = FL_DEF - 1;
    localparam int ADDR_MSB = FL_DEF - 2;
    localparam int ADDR_LSB = DATA_W_DEF;
    localparam int DATA_MSB = DATA_W_DEF - 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Total SCK rising edges in one frame
    function automatic int frame_len(input int aw, input int dw);
        return 1 + aw + dw;
    endfunction

endpackage

// File: rtl/spi_reg_slave_sync.sv
// Multi-bit synchroniser. The low EDGE_W bits also get rise/fall detect;
// the upper DLY_W bits are delay-only so they stay cycle-aligned with the
// edge-detected bits (mosi rides along with sck this way).
module spi_reg_slave_sync
    import spi_reg_slave_pkg::*;
#(
    parameter int STAGES = SYNC_STAGES_DEF,
    parameter int EDGE_W = 2,
    parameter int DLY_W  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [EDGE_W-1:0] edge_i,
    input  logic [DLY_W-1:0]  dly_i,
    output logic [EDGE_W-1:0] rise_o,
    output logic [EDGE_W-1:0] fall_o,
    output logic [DLY_W-1:0]  dly_o
);

    localparam int W = EDGE_W + DLY_W;

    logic [W-1:0]      stage_q [STAGES];
    logic [EDGE_W-1:0] prev_q;
    logic [W-1:0]      sync_s;

    // Flop chain plus one extra stage of history for edge detection.
    // Reset to 0 so a select already low at reset release is not seen as a fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < STAGES; s++) stage_q[s] <= '0;
            prev_q <= '0;
        end else begin
            stage_q[0] <= {dly_i, edge_i};
            for (int s = 1; s < STAGES; s++) stage_q[s] <= stage_q[s-1];
            prev_q <= sync_s[EDGE_W-1:0];
        end
    end

    assign sync_s = stage_q[STAGES-1];
    assign rise_o = sync_s[EDGE_W-1:0] & ~prev_q;
    assign fall_o = ~sync_s[EDGE_W-1:0] & prev_q;
    assign dly_o  = sync_s[W-1:EDGE_W];

endmodule

// File: rtl/spi_reg_slave.sv
// SPI mode-0 register responder. Each frame carries {rw, addr, wdata};
// reads return reg[addr] on miso during the last DATA_W SCK cycles of the
// same frame, writes commit at the end of a complete frame.
//
//   state | meaning
//   IDLE  | waiting for a synchronised ss falling edge
//   HDR   | shifting in rw/addr bits
//   DATA  | shifting in wdata, shifting out read data
//   DONE  | frame complete, waiting for ss to rise
module spi_reg_slave
    import spi_reg_slave_pkg::*;
#(
    parameter int                ADDR_W      = ADDR_W_DEF,
    parameter int                DATA_W      = DATA_W_DEF,
    parameter logic [DATA_W-1:0] ID_VAL      = DATA_W'(ID_VAL_DEF),
    parameter int                SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             sck,
    input  logic                             ss,
    input  logic                             mosi,
    output logic                             miso,
    output logic [DATA_W*(2**ADDR_W)-1:0]    regs,
    output logic                             wr_stb,
    output logic [ADDR_W-1:0]                wr_addr,
    output logic [DATA_W-1:0]                wr_data,
    output logic                             rd_stb,
    output logic                             frame_err
);

    localparam int NREG = 2 ** ADDR_W;
    localparam int FL   = frame_len(ADDR_W, DATA_W);
    localparam int HL   = 1 + ADDR_W;
    localparam int CW   = $clog2(FL + 1);

    localparam logic [CW-1:0] CNT_HDR   = CW'(HL);
    localparam logic [CW-1:0] CNT_TX_LO = CW'(HL + 1);
    localparam logic [CW-1:0] CNT_TX_HI = CW'(FL - 1);
    localparam logic [CW-1:0] CNT_END   = CW'(FL);

    logic [1:0] edge_rise, edge_fall;
    logic       sck_rise, sck_fall, ss_rise, ss_fall;
    logic       mosi_s;

    spi_reg_slave_sync #(
        .STAGES (SYNC_STAGES),
        .EDGE_W (2),
        .DLY_W  (1)
    ) u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .edge_i ({ss, sck}),
        .dly_i  (mosi),
        .rise_o (edge_rise),
        .fall_o (edge_fall),
        .dly_o  (mosi_s)
    );

    assign sck_rise = edge_rise[0];
    assign sck_fall = edge_fall[0];
    assign ss_rise  = edge_rise[1];
    assign ss_fall  = edge_fall[1];

    state_e              state_q;
    logic [CW-1:0]       cnt_q;
    logic [DATA_W-2:0]   rx_sh_q;
    logic [DATA_W-1:0]   tx_sh_q;
    logic                rw_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   reg_q [1:NREG-1];
    logic                wr_stb_q, rd_stb_q, frame_err_q;
    logic [ADDR_W-1:0]   wr_addr_q;
    logic [DATA_W-1:0]   wr_data_q;

    logic [CW-1:0]       cnt_d;
    logic [DATA_W-1:0]   rx_sh_d;
    logic                hdr_rw_d;
    logic [ADDR_W-1:0]   hdr_addr_d;
    logic [DATA_W-1:0]   reg_view [NREG];

    // Register 0 is a read-only ID; the rest come from storage.
    assign reg_view[0] = ID_VAL;
    for (genvar i = 1; i < NREG; i++) begin : g_view
        assign reg_view[i] = reg_q[i];
    end
    for (genvar i = 0; i < NREG; i++) begin : g_flat
        assign regs[i*DATA_W +: DATA_W] = reg_view[i];
    end

    // Values the frame would hold after the current sck rise is taken.
    // Only DATA_W bits of history are needed: the header is decoded after
    // HL bits and the write data is the last DATA_W bits.
    assign cnt_d      = cnt_q + 1'b1;
    assign rx_sh_d    = {rx_sh_q, mosi_s};
    assign hdr_rw_d   = rx_sh_d[ADDR_W];
    assign hdr_addr_d = rx_sh_d[ADDR_W-1:0];

    // Frame sequencer: bit counting, header decode, read load, write commit, abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            rx_sh_q     <= '0;
            tx_sh_q     <= '0;
            rw_q        <= 1'b0;
            addr_q      <= '0;
            wr_stb_q    <= 1'b0;
            rd_stb_q    <= 1'b0;
            frame_err_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            for (int i = 1; i < NREG; i++) reg_q[i] <= '0;
        end else begin
            wr_stb_q    <= 1'b0;
            rd_stb_q    <= 1'b0;
            frame_err_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (ss_fall) begin
                        state_q <= ST_HDR;
                        cnt_q   <= '0;
                        rx_sh_q <= '0;
                        tx_sh_q <= '0;
                    end
                end
                ST_HDR: begin
                    if (ss_rise) begin
                        state_q     <= ST_IDLE;
                        frame_err_q <= 1'b1;
                        cnt_q       <= '0;
                    end else if (sck_rise) begin
                        rx_sh_q <= rx_sh_d[DATA_W-2:0];
                        cnt_q   <= cnt_d;
                        if (cnt_d == CNT_HDR) begin
                            state_q <= ST_DATA;
                            rw_q    <= hdr_rw_d;
                            addr_q  <= hdr_addr_d;
                            if (!hdr_rw_d) begin
                                tx_sh_q  <= reg_view[hdr_addr_d];
                                rd_stb_q <= 1'b1;
                            end else begin
                                tx_sh_q <= '0;
                            end
                        end
                    end
                end
                ST_DATA: begin
                    if (ss_rise) begin
                        state_q     <= ST_IDLE;
                        frame_err_q <= 1'b1;
                        cnt_q       <= '0;
                        tx_sh_q     <= '0;
                    end else if (sck_rise) begin
                        rx_sh_q <= rx_sh_d[DATA_W-2:0];
                        cnt_q   <= cnt_d;
                        if (cnt_d == CNT_END) begin
                            state_q <= ST_DONE;
                            tx_sh_q <= '0;
                            if (rw_q && (addr_q != '0)) begin
                                reg_q[addr_q] <= rx_sh_d;
                                wr_addr_q     <= addr_q;
                                wr_data_q     <= rx_sh_d;
                                wr_stb_q      <= 1'b1;
                            end
                        end
                    end else if (sck_fall && (cnt_q >= CNT_TX_LO) && (cnt_q <= CNT_TX_HI)) begin
                        // The fall right after the header keeps the MSB in place
                        // so the master sees it on the next rise.
                        tx_sh_q <= {tx_sh_q[DATA_W-2:0], 1'b0};
                    end
                end
                ST_DONE: begin
                    if (ss_rise) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign miso      = (state_q == ST_DATA) & tx_sh_q[DATA_W-1];
    assign wr_stb    = wr_stb_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign rd_stb    = rd_stb_q;
    assign frame_err = frame_err_q;

endmodule

// File: doc/spi_reg_slave.md
Name: spi_reg_slave

Overview:
- SPI peripheral-side responder for the existing `spi_master` 12-bit-send / 8-bit-receive transaction.
- Each frame decodes a 12-bit MOSI command `{rw, addr[2:0], wdata[7:0]}` against a small register file.
- Returns 8-bit read data on MISO during the last 8 SCK cycles of the same frame.
- Sits on the FPGA side, facing the MCU or `spi_master`; exposes the register contents and write/read strobes to fabric logic.

Parameters:
- ADDR_W, 3, register address width; register count = 2**ADDR_W.
- DATA_W, 8, register width; equals the master receive length.
- ID_VAL, 8'hA5, constant returned by read-only register 0.
- SYNC_STAGES, 2, flip-flop depth of the sck/ss/mosi synchronisers (minimum 2).

Ports:
- clk  input  1  system clock; must be at least 8x the SCK frequency.
- rst_n  input  1  asynchronous active-low reset.
- sck  input  1  SPI clock, mode 0 (CPOL=0, CPHA=0), asynchronous to clk.
- ss  input  1  slave select, active low.
- mosi  input  1  master-out data, MSB first.
- miso  output  1  slave-out data, MSB first; driven 0 when not transmitting.
- regs  output  DATA_W*2**ADDR_W  flattened register file; reg i is bits [i*DATA_W +: DATA_W]; reg 0 reads ID_VAL.
- wr_stb  output  1  one-clk pulse when a write commits.
- wr_addr  output  ADDR_W  address of the last committed write.
- wr_data  output  DATA_W  data of the last committed write.
- rd_stb  output  1  one-clk pulse when read data is loaded for shifting.
- frame_err  output  1  one-clk pulse when ss rises before 12 SCK rising edges.

Behaviour:
- Reset:
  - All outputs 0, except reg 0 slice = ID_VAL. Regs 1..N-1 = 0.
  - State IDLE, bit counter 0, shift registers 0.
- Synchronisation and sampling:
  - sck, ss, mosi pass through identical SYNC_STAGES synchronisers, so mosi stays aligned with sck.
  - Edge detect on the synchronised sck/ss adds 1 cycle.
  - mosi is sampled on the synchronised sck rising edge.
- Frame length FL = 1+ADDR_W+DATA_W = 12.
- IDLE:
  - Leave only on a synchronised ss falling edge -> HDR, cnt=0.
  - ss already low when reset releases: no frame starts until ss goes high and then low again.
- HDR:
  - Each sck rise shifts mosi into rx_sh and increments cnt.
  - When cnt reaches 1+ADDR_W (4), latch rw/addr and go to DATA.
  - If rw=0: load tx_sh with reg[addr] (ID_VAL for addr 0) and pulse rd_stb in the same cycle.
  - If rw=1: load tx_sh with 0.
  - miso = tx_sh MSB combinationally from the register, so it is valid before the 5th sck rise.
- DATA:
  - sck rise: shift in mosi, cnt++.
  - sck fall: shift tx_sh left only while 5 <= cnt <= 11. The 4th falling edge must not shift (MSB preserved).
  - At cnt == 12 go to DONE.
  - If rw=1 and addr != 0: write reg[addr] = rx_sh[7:0], update wr_addr/wr_data, pulse wr_stb.
  - wr_stb rises SYNC_STAGES+1 clk cycles after the 12th sck rise.
  - Write to addr 0: ignored; no wr_stb, ID unchanged.
- DONE:
  - Further sck edges are ignored; miso = 0.
  - ss rise -> IDLE.
- Abort:
  - ss rise in HDR or DATA -> pulse frame_err, no write, no register change, back to IDLE, miso = 0.
- miso is 0 in IDLE, HDR and DONE.
- Back-to-back frames with ss high for at least 2 sck periods must each decode independently.
- rst_n low mid-frame: immediate return to the reset state. A partial write is never committed.

Decomposition:
- Shared header `spi_defs.vh`:
  - FL and field positions (RW_BIT=11, ADDR_MSB=10, ADDR_LSB=8, DATA_MSB=7).
  - State encodings IDLE/HDR/DATA/DONE (2 bits).
  - Defaults for ID_VAL and SYNC_STAGES.
- Sub-module `spi_sync`: parameterised N-stage synchroniser plus rise/fall detect. Instantiated for sck and ss; mosi uses its delay-only output.

Test Plan:
- Write reg 3: master sends 12'hB5A -> wr_stb pulses once, wr_addr=3, wr_data=8'h5A, regs[31:24]=8'h5A, frame_err=0.
- Read reg 3 after the write: master sends 12'h300 -> rd_stb pulses, master receives 8'h5A, no wr_stb.
- Read ID: master sends 12'h000 -> master receives 8'hA5. Then write 12'h8FF -> no wr_stb, next read of reg 0 still returns 8'hA5.
- Abort: ss rises after 6 SCK edges of 12'hB33 -> frame_err pulses once, reg 3 unchanged. A following complete 12'h300 read returns the prior value.
- Reset mid-frame:
  - Assert rst_n low after 8 SCK edges of a write to reg 2 -> all regs 0 except reg 0 = A5, outputs 0.
  - Remaining SCK edges with ss still low are ignored.
  - The next full frame after ss toggles decodes correctly.
- Back-to-back: writes 12'h911, 12'hA22, 12'hB33, then reads 12'h100/12'h200/12'h300 -> wr_stb three times; master receives 8'h11, 8'h22, 8'h33.
